hls_fp17_add_chn_a_rsci_rcv_buf: RTL and testbench

Input-side receive buffer for the fp17 adder's operand channel `chn_a`, the receiving end of the valid/ready channel protocol whose transmit end is the adder's output-channel wait logic. It accepts operands from upstream on a `vz`/`lz` handshake and holds up to two in a skid buffer. It presents the head operand to the HLS core and reports `wen_comp` so the core stalls when it requests an operand that is not yet available.

---
 rtl/hls_fp17_add_pkg.sv | 13 +
 rtl/hls_fp17_add_chn_a_rsci_rcv_buf_if.sv | 26 ++
 rtl/hls_fp17_add_chn_a_rsci_rcv_ctrl.sv | 65 ++++++
 rtl/hls_fp17_add_chn_a_rsci_rcv_buf.sv | 45 ++++
 tb/tb_hls_fp17_add_chn_a_rsci_rcv_buf.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/hls_fp17_add_pkg.sv
// Shared types for the fp17 adder channel buffers.
// Occupancy state encodes the operand count directly.
package hls_fp17_add_pkg;
  localparam int FP17_W = 17;

  typedef logic [1:0] rcv_cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rcv_state_t;
endpackage

// File: rtl/hls_fp17_add_chn_a_rsci_rcv_buf_if.sv
// chn_a operand channel: upstream vz/lz handshake plus core-side request/stall.
interface hls_fp17_add_chn_a_rsci_rcv_buf_if
  import hls_fp17_add_pkg::*;
#(
  parameter int WIDTH = FP17_W
);
  logic [WIDTH-1:0] chn_a_rsc_z;
  logic             chn_a_rsc_vz;
  logic             chn_a_rsc_lz;
  logic             chn_a_rsci_oswt;
  logic             core_en;
  logic             chn_a_rsci_wen_comp;
  logic [WIDTH-1:0] chn_a_rsci_d_mxwt;
  rcv_cnt_t         chn_a_rsci_cnt;

  // master: upstream producer + HLS core; slave: the receive buffer
  modport master (
    output chn_a_rsc_z, chn_a_rsc_vz, chn_a_rsci_oswt, core_en,
    input  chn_a_rsc_lz, chn_a_rsci_wen_comp, chn_a_rsci_d_mxwt, chn_a_rsci_cnt
  );

  modport slave (
    input  chn_a_rsc_z, chn_a_rsc_vz, chn_a_rsci_oswt, core_en,
    output chn_a_rsc_lz, chn_a_rsci_wen_comp, chn_a_rsci_d_mxwt, chn_a_rsci_cnt
  );
endinterface

// File: rtl/hls_fp17_add_chn_a_rsci_rcv_ctrl.sv
// Occupancy FSM for the chn_a skid buffer: push/pop decode, ready, stall,
// and the load strobes that steer the head/tail data registers.
module hls_fp17_add_chn_a_rsci_rcv_ctrl
  import hls_fp17_add_pkg::*;
(
  input  logic     nvdla_core_clk,
  input  logic     nvdla_core_rst,
  input  logic     vz,
  input  logic     oswt,
  input  logic     core_en,
  output logic     lz,
  output logic     wen_comp,
  output logic     load_head,
  output logic     load_tail,
  output logic     head_from_tail,
  output rcv_cnt_t cnt
);
  rcv_state_t state_q, state_d;
  logic       push, pop;

  // Ready depends only on registered state (and reset), never on vz/oswt.
  assign lz       = ~nvdla_core_rst & (state_q != TWO);
  assign push     = vz & lz;
  assign pop      = oswt & core_en & (state_q != EMPTY);
  assign wen_comp = ~oswt | (state_q != EMPTY);
  assign cnt      = rcv_cnt_t'(state_q);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state_q <= EMPTY;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        // push+pop replaces the head in place: full-rate streaming stays in ONE
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_d   = TWO;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
endmodule

// File: rtl/hls_fp17_add_chn_a_rsci_rcv_buf.sv
// chn_a receive buffer: two-entry skid buffer between upstream and the core.
// The core always sees the registered head; there is no z->d_mxwt bypass.
module hls_fp17_add_chn_a_rsci_rcv_buf
  import hls_fp17_add_pkg::*;
#(
  parameter int WIDTH = FP17_W
)(
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  hls_fp17_add_chn_a_rsci_rcv_buf_if.slave chn_a
);
  logic [WIDTH-1:0] head_q, tail_q;
  logic             load_head, load_tail, head_from_tail;

  hls_fp17_add_chn_a_rsci_rcv_ctrl u_ctrl (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .vz             (chn_a.chn_a_rsc_vz),
    .oswt           (chn_a.chn_a_rsci_oswt),
    .core_en        (chn_a.core_en),
    .lz             (chn_a.chn_a_rsc_lz),
    .wen_comp       (chn_a.chn_a_rsci_wen_comp),
    .load_head      (load_head),
    .load_tail      (load_tail),
    .head_from_tail (head_from_tail),
    .cnt            (chn_a.chn_a_rsci_cnt)
  );

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      head_q <= '0;
    end else if (head_from_tail) begin
      head_q <= tail_q;
    end else if (load_head) begin
      head_q <= chn_a.chn_a_rsc_z;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst)  tail_q <= '0;
    else if (load_tail)  tail_q <= chn_a.chn_a_rsc_z;
  end

  assign chn_a.chn_a_rsci_d_mxwt = head_q;
endmodule

// File: tb/tb_hls_fp17_add_chn_a_rsci_rcv_buf.sv
// Directed table + corner sequences + random scoreboard for the chn_a receive buffer.
module tb_hls_fp17_add_chn_a_rsci_rcv_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hls_fp17_add_chn_a_rsci_rcv_buf_if #(.WIDTH(17)) bus ();

  hls_fp17_add_chn_a_rsci_rcv_buf #(.WIDTH(17)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .chn_a          (bus)
  );

  typedef struct {
    logic        vz;
    logic [16:0] z;
    logic        oswt;
    logic        en;
    logic        e_lz;
    logic        e_wen;
    logic [1:0]  e_cnt;
    logic [16:0] e_d;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic vz, input logic [16:0] z, input logic oswt, input logic en,
                     input logic e_lz, input logic e_wen, input logic [1:0] e_cnt,
                     input logic [16:0] e_d);
    vec_t v;
    v.vz = vz; v.z = z; v.oswt = oswt; v.en = en;
    v.e_lz = e_lz; v.e_wen = e_wen; v.e_cnt = e_cnt; v.e_d = e_d;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic vz, input logic [16:0] z, input logic oswt, input logic en);
    bus.chn_a_rsc_vz    = vz;
    bus.chn_a_rsc_z     = z;
    bus.chn_a_rsci_oswt = oswt;
    bus.core_en         = en;
  endtask

  initial begin
    logic [16:0] q[$];
    logic        vz, oswt, en, m_push, m_pop;
    logic [16:0] z;

    drive(1'b1, 17'h1ABCD, 1'b0, 1'b1);

    // reset with vz held: nothing accepted until lz returns
    repeat (2) @(negedge clk);
    chk("rst_lz", 32'(bus.chn_a_rsc_lz), 32'd0);
    chk("rst_cnt", 32'(bus.chn_a_rsci_cnt), 32'd0);
    chk("rst_d", 32'(bus.chn_a_rsci_d_mxwt), 32'd0);
    chk("rst_wen", 32'(bus.chn_a_rsci_wen_comp), 32'd1);
    rst = 1'b0;
    #1;
    chk("rel_lz", 32'(bus.chn_a_rsc_lz), 32'd1);
    @(negedge clk);
    chk("rel_cnt", 32'(bus.chn_a_rsci_cnt), 32'd1);
    chk("rel_d", 32'(bus.chn_a_rsci_d_mxwt), 32'h1ABCD);
    drive(1'b0, 17'h0, 1'b0, 1'b1);

    // drain 1ABCD
    add(0, 17'h0, 1, 1, 1, 1, 1, 17'h1ABCD);
    // streaming 1..8 with a popping core
    add(1, 17'd1, 1, 1, 1, 0, 0, 17'h1ABCD);
    for (int k = 1; k <= 7; k++) add(1, 17'(k + 1), 1, 1, 1, 1, 1, 17'(k));
    add(0, 17'h0, 1, 1, 1, 1, 1, 17'd8);
    // empty request, then push 1FFFF
    add(0, 17'h0, 1, 1, 1, 0, 0, 17'd8);
    add(0, 17'h0, 1, 1, 1, 0, 0, 17'd8);
    add(1, 17'h1FFFF, 1, 1, 1, 0, 0, 17'd8);
    add(0, 17'h0, 1, 1, 1, 1, 1, 17'h1FFFF);
    // stall and skid
    add(1, 17'h00011, 0, 1, 1, 1, 0, 17'h1FFFF);
    add(1, 17'h00022, 1, 0, 1, 1, 1, 17'h00011);
    add(1, 17'h00033, 1, 0, 0, 1, 2, 17'h00011);
    add(1, 17'h00033, 1, 0, 0, 1, 2, 17'h00011);
    add(1, 17'h00033, 1, 1, 0, 1, 2, 17'h00011);
    add(1, 17'h00033, 1, 1, 1, 1, 1, 17'h00022);
    add(0, 17'h0, 1, 1, 1, 1, 1, 17'h00033);
    add(0, 17'h0, 0, 1, 1, 1, 0, 17'h00033);
    // fill to TWO for the mid-operation reset
    add(1, 17'h00044, 0, 1, 1, 1, 0, 17'h00033);
    add(1, 17'h00055, 0, 1, 1, 1, 1, 17'h00044);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].vz, tbl[i].z, tbl[i].oswt, tbl[i].en);
      #1;
      chk($sformatf("v%0d_lz", i), 32'(bus.chn_a_rsc_lz), 32'(tbl[i].e_lz));
      chk($sformatf("v%0d_wen", i), 32'(bus.chn_a_rsci_wen_comp), 32'(tbl[i].e_wen));
      chk($sformatf("v%0d_cnt", i), 32'(bus.chn_a_rsci_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_d", i), 32'(bus.chn_a_rsci_d_mxwt), 32'(tbl[i].e_d));
    end

    // async reset pulse between edges while in TWO
    @(negedge clk);
    drive(1'b0, 17'h0, 1'b1, 1'b1);
    #1;
    chk("mid_pre_cnt", 32'(bus.chn_a_rsci_cnt), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("mid_cnt", 32'(bus.chn_a_rsci_cnt), 32'd0);
    chk("mid_d", 32'(bus.chn_a_rsci_d_mxwt), 32'd0);
    chk("mid_lz", 32'(bus.chn_a_rsc_lz), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_cnt", 32'(bus.chn_a_rsci_cnt), 32'd0);
    chk("post_d", 32'(bus.chn_a_rsci_d_mxwt), 32'd0);
    chk("post_wen", 32'(bus.chn_a_rsci_wen_comp), 32'd0);
    chk("post_lz", 32'(bus.chn_a_rsc_lz), 32'd1);
    @(negedge clk);
    chk("post2_cnt", 32'(bus.chn_a_rsci_cnt), 32'd0);

    // random traffic against a reference queue (buffer is empty here)
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      vz   = 1'($urandom_range(0, 1));
      oswt = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 3) != 0);
      z    = 17'($urandom);
      drive(vz, z, oswt, en);
      #1;
      chk("rnd_cnt", 32'(bus.chn_a_rsci_cnt), 32'(q.size()));
      chk("rnd_lz", 32'(bus.chn_a_rsc_lz), 32'(q.size() != 2));
      chk("rnd_wen", 32'(bus.chn_a_rsci_wen_comp), 32'(!oswt || q.size() != 0));
      if (q.size() != 0) chk("rnd_d", 32'(bus.chn_a_rsci_d_mxwt), 32'(q[0]));
      m_push = vz && (q.size() != 2);
      m_pop  = oswt && en && (q.size() != 0);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
